// File: rtl/pht_update_ctrl.sv
// pht_update_ctrl
//   Write-side controller for the 2-bit pattern history table RAM.
//   After reset or a reinit pulse it sweeps every entry to INIT_VAL, then
//   arbitrates saturating-counter updates from two resolution lanes onto the
//   single RAM write port through a registered read-modify-write pipeline.
//
// Ports
//   CLK, RST                      clock, synchronous active-high reset
//   reinit                        pulse: restart the init sweep
//   req{0,1}_valid/_idx/_taken    update request lanes
//   req{0,1}_ready                lane accepted when valid & ready
//   init_done                     sweep complete, updates accepted
//   ram_ar / ram_q                read address (A2) / async read data (Q2)
//   ram_wen, ram_cen              write enable (CEN mirrors WEN)
//   ram_aw, ram_di                write address / write data
module pht_update_ctrl #(
  parameter int unsigned IDX_W    = 5,
  parameter logic [1:0]  INIT_VAL = 2'b01
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             reinit,
  input  logic             req0_valid,
  input  logic [IDX_W-1:0] req0_idx,
  input  logic             req0_taken,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [IDX_W-1:0] req1_idx,
  input  logic             req1_taken,
  output logic             req1_ready,
  output logic             init_done,
  output logic [IDX_W-1:0] ram_ar,
  input  logic [1:0]       ram_q,
  output logic             ram_wen,
  output logic             ram_cen,
  output logic [IDX_W-1:0] ram_aw,
  output logic [1:0]       ram_di
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t           state, state_nx;
  logic [IDX_W-1:0] sc, sc_nx;
  logic             rr, rr_nx;
  logic             s1_valid, s1_valid_nx;
  logic [IDX_W-1:0] s1_idx, s1_idx_nx;
  logic             s1_taken, s1_taken_nx;
  logic [1:0]       s1_cnt, s1_cnt_nx;

  logic             grant0, grant1;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_taken;
  logic [1:0]       w_di;
  logic [1:0]       cnt_in;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_INIT;
      sc       <= '0;
      rr       <= 1'b0;
      s1_valid <= 1'b0;
      s1_idx   <= '0;
      s1_taken <= 1'b0;
      s1_cnt   <= '0;
    end else begin
      state    <= state_nx;
      sc       <= sc_nx;
      rr       <= rr_nx;
      s1_valid <= s1_valid_nx;
      s1_idx   <= s1_idx_nx;
      s1_taken <= s1_taken_nx;
      s1_cnt   <= s1_cnt_nx;
    end
  end

  // Round-robin only matters when both lanes contend.
  assign grant0    = req0_valid & (~req1_valid | ~rr);
  assign grant1    = req1_valid & (~req0_valid |  rr);
  assign sel_idx   = grant1 ? req1_idx   : req0_idx;
  assign sel_taken = grant1 ? req1_taken : req0_taken;

  // Saturating 2-bit counter update for the entry in stage W.
  always_comb begin
    w_di = s1_cnt;
    if (s1_taken) begin
      if (s1_cnt != 2'b11) w_di = s1_cnt + 2'b01;
    end else begin
      if (s1_cnt != 2'b00) w_di = s1_cnt - 2'b01;
    end
  end

  // Stage W writes the RAM at this edge, so ram_q is stale for that index.
  assign cnt_in = (s1_valid && (s1_idx == sel_idx)) ? w_di : ram_q;

  always_comb begin
    state_nx    = state;
    sc_nx       = sc;
    rr_nx       = rr;
    s1_valid_nx = 1'b0;
    s1_idx_nx   = s1_idx;
    s1_taken_nx = s1_taken;
    s1_cnt_nx   = s1_cnt;
    case (state)
      S_INIT: begin
        sc_nx = sc + 1'b1;
        if (sc == '1) state_nx = S_RUN;
        if (reinit) begin
          sc_nx    = '0;
          state_nx = S_INIT;
        end
      end
      default: begin
        if (reinit) begin
          state_nx = S_INIT;
          sc_nx    = '0;
        end else if (grant0 | grant1) begin
          s1_valid_nx = 1'b1;
          s1_idx_nx   = sel_idx;
          s1_taken_nx = sel_taken;
          s1_cnt_nx   = cnt_in;
          if (req0_valid & req1_valid) rr_nx = ~rr;
        end
      end
    endcase
  end

  // Outputs are forced to their reset values combinationally while RST is high.
  always_comb begin
    ram_wen    = 1'b0;
    ram_aw     = '0;
    ram_di     = INIT_VAL;
    ram_ar     = '0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    init_done  = 1'b0;
    if (!RST) begin
      ram_ar    = sel_idx;
      init_done = (state == S_RUN);
      if (state == S_RUN) begin
        req0_ready = ~reinit & grant0;
        req1_ready = ~reinit & grant1;
      end
      if (state == S_INIT) begin
        ram_wen = 1'b1;
        ram_aw  = sc;
        ram_di  = INIT_VAL;
      end else if (s1_valid) begin
        ram_wen = 1'b1;
        ram_aw  = s1_idx;
        ram_di  = w_di;
      end
    end
  end

  assign ram_cen = ram_wen;

endmodule

// File: tb/tb_pht_update_ctrl.sv
// Testbench for pht_update_ctrl: RAM model plus a behavioural reference
// model of the table contents, arbitration and expected write stream.
module tb_pht_update_ctrl;

  localparam int unsigned IDX_W = 5;
  localparam int unsigned DEPTH = 32;
  localparam logic [1:0]  IV    = 2'b01;

  logic             clk = 1'b0;
  logic             rst;
  logic             reinit;
  logic             v0, t0, v1, t1;
  logic [IDX_W-1:0] i0, i1;
  logic             r0, r1, init_done;
  logic [IDX_W-1:0] ram_ar, ram_aw;
  logic [1:0]       ram_q, ram_di;
  logic             ram_wen, ram_cen;

  logic [1:0] ram [DEPTH];

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [1:0]       exp_mem [DEPTH];
  bit               m_init;
  int unsigned      m_sc;
  bit               m_rr;
  bit               pend_v;
  logic [IDX_W-1:0] pend_idx;
  logic [1:0]       pend_val;

  always #5 clk = ~clk;

  pht_update_ctrl #(.IDX_W(IDX_W), .INIT_VAL(IV)) dut (
    .CLK(clk), .RST(rst), .reinit(reinit),
    .req0_valid(v0), .req0_idx(i0), .req0_taken(t0), .req0_ready(r0),
    .req1_valid(v1), .req1_idx(i1), .req1_taken(t1), .req1_ready(r1),
    .init_done(init_done), .ram_ar(ram_ar), .ram_q(ram_q),
    .ram_wen(ram_wen), .ram_cen(ram_cen), .ram_aw(ram_aw), .ram_di(ram_di)
  );

  always @(posedge clk) if (ram_wen) ram[ram_aw] <= ram_di;
  assign ram_q = ram[ram_ar];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] sat(input logic [1:0] c, input logic t);
    int v;
    v = int'(c) + (t ? 1 : -1);
    if (v > 3) v = 3;
    if (v < 0) v = 0;
    return v[1:0];
  endfunction

  task automatic reset_cycles(input int n);
    rst = 1'b1;
    for (int k = 0; k < n; k++) begin
      v0 = 1'($urandom); v1 = 1'($urandom); reinit = 1'b0;
      i0 = IDX_W'($urandom); i1 = IDX_W'($urandom);
      @(negedge clk);
      chk("rst_wen", ram_wen, 0);
      chk("rst_cen", ram_cen, 0);
      chk("rst_done", init_done, 0);
      chk("rst_rdy0", r0, 0);
      chk("rst_rdy1", r1, 0);
      chk("rst_aw", ram_aw, 0);
      chk("rst_di", ram_di, IV);
      chk("rst_ar", ram_ar, 0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    v0 = 1'b0; v1 = 1'b0;
    m_init = 1'b1; m_sc = 0; m_rr = 1'b0; pend_v = 1'b0;
  endtask

  // One clock cycle: drive, check at the falling edge, advance the model.
  task automatic cycle(input logic a_v, input logic [IDX_W-1:0] a_i, input logic a_t,
                       input logic b_v, input logic [IDX_W-1:0] b_i, input logic b_t,
                       input logic rein);
    bit g0, g1, e_wen;
    logic [IDX_W-1:0] gi;
    logic gt;
    v0 = a_v; i0 = a_i; t0 = a_t;
    v1 = b_v; i1 = b_i; t1 = b_t;
    reinit = rein;
    g0 = 0; g1 = 0;
    if (!m_init && !rein) begin
      if (a_v && b_v) begin g0 = !m_rr; g1 = m_rr; end
      else begin g0 = a_v; g1 = b_v; end
    end
    @(negedge clk);
    chk("init_done", init_done, !m_init);
    chk("ready0", r0, g0);
    chk("ready1", r1, g1);
    e_wen = m_init || pend_v;
    chk("wen", ram_wen, e_wen);
    chk("cen", ram_cen, e_wen);
    if (m_init) begin
      chk("sweep_aw", ram_aw, m_sc);
      chk("sweep_di", ram_di, IV);
    end else if (pend_v) begin
      chk("upd_aw", ram_aw, pend_idx);
      chk("upd_di", ram_di, pend_val);
    end
    if (m_init) begin
      exp_mem[m_sc] = IV;
      pend_v = 0;
      if (rein) m_sc = 0;
      else if (m_sc == DEPTH - 1) m_init = 0;
      else m_sc++;
    end else if (rein) begin
      m_init = 1; m_sc = 0; pend_v = 0;
    end else if (g0 || g1) begin
      gi = g1 ? b_i : a_i;
      gt = g1 ? b_t : a_t;
      exp_mem[gi] = sat(exp_mem[gi], gt);
      pend_v = 1; pend_idx = gi; pend_val = exp_mem[gi];
      if (a_v && b_v) m_rr = !m_rr;
    end else begin
      pend_v = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(0, '0, 0, 0, '0, 0, 0);
  endtask

  initial begin
    logic [1:0] sat_exp [8];
    sat_exp = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00};
    for (int k = 0; k < DEPTH; k++) begin
      ram[k] = 2'($urandom);
      exp_mem[k] = 2'b00;
    end
    rst = 1'b1; reinit = 1'b0;
    v0 = 0; v1 = 0; t0 = 0; t1 = 0; i0 = '0; i1 = '0;
    #1;

    // Reset sweep
    reset_cycles(3);
    idle(32);
    for (int k = 0; k < DEPTH; k++) chk("sweep_mem", ram[k], IV);
    idle(1);

    // Saturation on idx 7
    for (int k = 0; k < 8; k++) begin
      cycle(1, 5'd7, k < 4, 0, '0, 0, 0);
      idle(1);
      chk("sat_mem7", ram[7], sat_exp[k]);
    end

    // Back-to-back same index: forwarding
    cycle(1, 5'd5, 1, 0, '0, 0, 0);
    cycle(1, 5'd5, 1, 0, '0, 0, 0);
    cycle(0, '0, 0, 1, 5'd5, 1, 0);
    idle(1);
    chk("fwd_mem5", ram[5], 2'b11);

    // Arbitration: both lanes valid for 4 cycles
    for (int k = 0; k < 4; k++) cycle(1, 5'd1, 1, 1, 5'd2, 1, 0);
    idle(1);
    chk("arb_mem1", ram[1], 2'b11);
    chk("arb_mem2", ram[2], 2'b11);
    cycle(1, 5'd3, 0, 1, 5'd4, 0, 0);   // rr back at 0: lane 0 wins
    idle(1);

    // Reinit while S1 holds an idx 9 update and lane 1 is valid
    cycle(1, 5'd9, 1, 0, '0, 0, 0);
    cycle(0, '0, 0, 1, 5'd3, 1, 1);
    for (int k = 0; k < 32; k++)
      cycle(1'($urandom), IDX_W'($urandom), 1, 1'($urandom), IDX_W'($urandom), 0, 0);
    chk("reinit_mem9", ram[9], IV);

    // Randomized traffic against the reference model
    for (int k = 0; k < 400; k++) begin
      logic a_v, b_v, a_t, b_t, rn;
      logic [IDX_W-1:0] a_i, b_i;
      a_v = ($urandom_range(0, 3) != 0);
      b_v = ($urandom_range(0, 3) != 0);
      a_t = 1'($urandom); b_t = 1'($urandom);
      a_i = ($urandom_range(0, 1) == 1) ? IDX_W'($urandom_range(0, 3)) : IDX_W'($urandom);
      b_i = ($urandom_range(0, 1) == 1) ? IDX_W'($urandom_range(0, 3)) : IDX_W'($urandom);
      rn  = ($urandom_range(0, 79) == 0);
      cycle(a_v, a_i, a_t, b_v, b_i, b_t, rn);
    end
    idle(34);
    for (int k = 0; k < DEPTH; k++) chk("rand_mem", ram[k], exp_mem[k]);

    // RST in the middle of a sweep
    cycle(1, 5'd12, 1, 0, '0, 0, 1);
    idle(10);
    reset_cycles(2);
    idle(33);
    chk("rst_sweep_done", init_done, 1);
    for (int k = 0; k < DEPTH; k++) chk("rst_sweep_mem", ram[k], IV);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
